exe_stage_mc: RTL and testbench
===============================

Name: exe_stage_mc

Overview:
Parametrised, multi-cycle successor to the single-cycle ARM execute stage. Keeps the same ALU command set, status-register and EXE/MEM pipeline-register role. Adds width generalisation, an iterative MUL/MLA unit with a busy/ready handshake to decode, a downstream freeze, and a branch-flush. Sits between the ID/EXE register and the MEM stage.

Parameters:
WIDTH, 32, datapath width in bits; must be ≥8.
MUL_BITS, 4, multiplier bits consumed per iteration; WIDTH must be a multiple of MUL_BITS.
CYCLES (localparam), WIDTH/MUL_BITS, number of multiply iterations.

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous reset, active-low
in_valid  in  1  ID/EXE presents an instruction
in_ready  out  1  stage can accept; when low, upstream holds
exe_cmd  in  4  ALU command: 0001 MOV, 1001 MVN, 0010 ADD, 0011 ADC, 0100 SUB, 0101 SBC, 0110 AND, 0111 ORR, 1000 EOR, 1010 MUL, 1011 MLA
s_in  in  1  update status on completion
carry_in  in  1  C flag for ADC/SBC
mem_w_en_in, mem_r_en_in, wb_en_in  in  1 each  control passed to MEM
dest_in  in  4  destination register
rn_value  in  WIDTH  operand 1 / multiplicand
val2  in  WIDTH  operand 2 / multiplier, already shifted or immediate
store_in  in  WIDTH  store data; also the MLA accumulator
freeze  in  1  downstream stall
flush  in  1  branch taken; kill the in-flight instruction
status_bits  out  4  {N,Z,C,V}, registered
out_valid  out  1  EXE/MEM register holds a valid instruction
alu_result, store_value  out  WIDTH  registered results
dest_out  out  4  registered destination
mem_w_en, mem_r_en, wb_en  out  1 each  registered control; forced 0 when out_valid=0
busy  out  1  multiply in progress; used by hazard unit

Behaviour:
- Reset (rst=0, async): FSM→IDLE; all outputs 0; status_bits=0000; in_ready=1 after release. Reset mid-multiply discards the operation.
- FSM states: IDLE, MUL_BUSY.
- IDLE: in_ready = ~freeze. Accept = in_valid & in_ready & ~flush.
  - Non-multiply accept: output register loads the result on the same edge (1-cycle latency), out_valid=1.
  - MUL/MLA accept: capture operands, counter=0, enter MUL_BUSY. Output register loads a bubble: out_valid=0, enables 0.
  - No accept: output register loads a bubble (unless freeze).
- MUL_BUSY: in_ready=0, busy=1.
  - Each non-frozen edge adds one MUL_BITS-bit partial product (radix-2^MUL_BITS shift-add) and increments counter.
  - The edge with counter=CYCLES-1 writes result[WIDTH-1:0] (+store_in for MLA, modulo 2^WIDTH) to alu_result, sets out_valid=1, returns to IDLE.
  - in_ready is asserted the cycle after that edge.
  - Net latency: CYCLES edges after accept.
  - The output register holds a bubble during MUL_BUSY.
- Arithmetic (WIDTH bits, modulo):
  - ADD/ADC/SUB/SBC produce C as carry-out; for subtract, C=1 means no borrow. SBC = rn − val2 − ~carry_in.
  - V uses signed overflow on the MSB.
  - Logic/MOV/MVN: C and V unchanged.
  - MUL/MLA: N and Z only; C and V unchanged.
- Status: on the edge the output register loads a valid instruction with s_in=1, status_bits ← {N,Z,C,V} (mixed with held C/V as above). Never updated on bubbles, flush or freeze.
- freeze=1: output register, status, FSM and counter all hold; in_ready=0.
- flush=1 (synchronous, priority over freeze and accept): output register loads a bubble; MUL_BUSY aborts to IDLE with no status update.
- Simultaneous flush and completion edge: flush wins; result is discarded.
- store_value and dest_out are captured from store_in and dest_in at accept time and presented with the result.

Test Plan:
- WIDTH=32. ADD rn=0x7FFFFFFF, val2=1, s_in=1 → next edge: alu_result=0x80000000, out_valid=1, status_bits=1001.
- SUB rn=5, val2=5, s_in=1 → alu_result=0, status_bits=0110. Follow with AND s_in=1 → C and V stay as set by the SUB.
- MUL rn=7, val2=6, MUL_BITS=4 → in_ready=0 for 8 edges; alu_result=42, out_valid=1 on the 8th edge after accept; no valid outputs in between.
- MLA rn=0xFFFFFFFF, val2=2, store_in=3 → alu_result=0x00000001 (wrap); s_in=1 gives N=0, Z=0, C/V preserved.
- freeze high for 3 cycles mid-MUL → completion delayed exactly 3 edges; result unchanged. flush mid-MUL → out_valid stays 0, in_ready=1 next cycle, status unchanged.
- rst low mid-MUL (async, between edges) → outputs immediately 0, status=0000; a new ADD after release completes in 1 cycle.

Source files
------------

// File: rtl/exe_stage_mc.sv
// rtl/exe_stage_mc.sv - multi-cycle ARM execute stage with iterative MUL/MLA
// Purpose: ALU for MOV/MVN/ADD/ADC/SUB/SBC/AND/ORR/EOR in one cycle, shift-add
//          MUL/MLA over WIDTH/MUL_BITS cycles, NZCV status register and the
//          EXE/MEM pipeline register, with freeze (hold) and flush (kill).
// Ports:   clk, rst (async, active-low); in_valid/in_ready handshake from ID/EXE;
//          exe_cmd, s_in, carry_in, mem/wb enables, dest_in, rn_value, val2,
//          store_in instruction fields; freeze, flush pipeline controls;
//          status_bits {N,Z,C,V}; out_valid, alu_result, store_value, dest_out,
//          mem_w_en, mem_r_en, wb_en to MEM; busy to the hazard unit.
module exe_stage_mc #(
    parameter int WIDTH    = 32,
    parameter int MUL_BITS = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       exe_cmd,
    input  logic             s_in,
    input  logic             carry_in,
    input  logic             mem_w_en_in,
    input  logic             mem_r_en_in,
    input  logic             wb_en_in,
    input  logic [3:0]       dest_in,
    input  logic [WIDTH-1:0] rn_value,
    input  logic [WIDTH-1:0] val2,
    input  logic [WIDTH-1:0] store_in,
    input  logic             freeze,
    input  logic             flush,
    output logic [3:0]       status_bits,
    output logic             out_valid,
    output logic [WIDTH-1:0] alu_result,
    output logic [WIDTH-1:0] store_value,
    output logic [3:0]       dest_out,
    output logic             mem_w_en,
    output logic             mem_r_en,
    output logic             wb_en,
    output logic             busy
);
    localparam int CYCLES = WIDTH / MUL_BITS;
    localparam int CNT_W  = (CYCLES > 1) ? $clog2(CYCLES) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CYCLES - 1);

    localparam logic [3:0] CMD_MOV = 4'b0001, CMD_MVN = 4'b1001, CMD_ADD = 4'b0010,
                           CMD_ADC = 4'b0011, CMD_SUB = 4'b0100, CMD_SBC = 4'b0101,
                           CMD_AND = 4'b0110, CMD_ORR = 4'b0111, CMD_EOR = 4'b1000,
                           CMD_MUL = 4'b1010, CMD_MLA = 4'b1011;

    typedef enum logic {S_IDLE, S_MUL_BUSY} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] mcand_q, mcand_d, mplier_q, mplier_d, acc_q, acc_d;
    logic [WIDTH-1:0] hstore_q, hstore_d;
    logic [3:0]       hdest_q, hdest_d;
    logic [2:0]       hctl_q, hctl_d;      // {mem_w, mem_r, wb} of the pending multiply
    logic             hs_q, hs_d, mla_q, mla_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] alu_result_q, alu_result_d, store_value_q, store_value_d;
    logic [3:0]       dest_q, dest_d, status_q, status_d;
    logic [2:0]       out_ctl_q, out_ctl_d;

    logic [WIDTH-1:0] op2, alu_r, pp, mul_sum, mul_final;
    logic [WIDTH:0]   sum;
    logic             cin_eff, is_arith, is_mul, alu_c, alu_v, accept;

    // Single-cycle ALU; subtracts are a + ~b + cin so C=1 means no borrow.
    always_comb begin
        op2      = val2;
        cin_eff  = 1'b0;
        is_arith = 1'b0;
        case (exe_cmd)
            CMD_ADD: is_arith = 1'b1;
            CMD_ADC: begin is_arith = 1'b1; cin_eff = carry_in; end
            CMD_SUB: begin is_arith = 1'b1; op2 = ~val2; cin_eff = 1'b1; end
            CMD_SBC: begin is_arith = 1'b1; op2 = ~val2; cin_eff = carry_in; end
            default: ;
        endcase
        sum = {1'b0, rn_value} + {1'b0, op2} + {{WIDTH{1'b0}}, cin_eff};
        case (exe_cmd)
            CMD_MOV: alu_r = val2;
            CMD_MVN: alu_r = ~val2;
            CMD_AND: alu_r = rn_value & val2;
            CMD_ORR: alu_r = rn_value | val2;
            CMD_EOR: alu_r = rn_value ^ val2;
            CMD_ADD, CMD_ADC, CMD_SUB, CMD_SBC: alu_r = sum[WIDTH-1:0];
            default: alu_r = '0;
        endcase
        alu_c  = sum[WIDTH];
        alu_v  = (rn_value[WIDTH-1] == op2[WIDTH-1]) && (sum[WIDTH-1] != rn_value[WIDTH-1]);
        is_mul = (exe_cmd == CMD_MUL) || (exe_cmd == CMD_MLA);
    end

    // Radix-2^MUL_BITS shift-add: multiplicand shifts up, multiplier digits shift out low.
    always_comb begin
        pp        = mcand_q * WIDTH'(mplier_q[MUL_BITS-1:0]);
        mul_sum   = acc_q + pp;
        mul_final = mul_sum + (mla_q ? hstore_q : '0);
    end

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        mcand_d       = mcand_q;
        mplier_d      = mplier_q;
        acc_d         = acc_q;
        hstore_d      = hstore_q;
        hdest_d       = hdest_q;
        hctl_d        = hctl_q;
        hs_d          = hs_q;
        mla_d         = mla_q;
        out_valid_d   = out_valid_q;
        alu_result_d  = alu_result_q;
        store_value_d = store_value_q;
        dest_d        = dest_q;
        out_ctl_d     = out_ctl_q;
        status_d      = status_q;

        in_ready = rst && (state_q == S_IDLE) && !freeze;
        busy     = (state_q == S_MUL_BUSY);
        accept   = in_valid && in_ready && !flush;

        if (flush) begin
            out_valid_d = 1'b0;
            out_ctl_d   = '0;
            state_d     = S_IDLE;
        end else if (!freeze) begin
            // Bubble by default; overwritten below when a result is loaded.
            out_valid_d = 1'b0;
            out_ctl_d   = '0;
            if (state_q == S_MUL_BUSY) begin
                acc_d    = mul_sum;
                mcand_d  = mcand_q << MUL_BITS;
                mplier_d = mplier_q >> MUL_BITS;
                cnt_d    = cnt_q + 1'b1;
                if (cnt_q == LAST_CNT) begin
                    state_d       = S_IDLE;
                    out_valid_d   = 1'b1;
                    alu_result_d  = mul_final;
                    store_value_d = hstore_q;
                    dest_d        = hdest_q;
                    out_ctl_d     = hctl_q;
                    if (hs_q)
                        status_d = {mul_final[WIDTH-1], mul_final == '0, status_q[1:0]};
                end
            end else if (accept) begin
                if (is_mul) begin
                    state_d  = S_MUL_BUSY;
                    cnt_d    = '0;
                    acc_d    = '0;
                    mcand_d  = rn_value;
                    mplier_d = val2;
                    hstore_d = store_in;
                    hdest_d  = dest_in;
                    hctl_d   = {mem_w_en_in, mem_r_en_in, wb_en_in};
                    hs_d     = s_in;
                    mla_d    = (exe_cmd == CMD_MLA);
                end else begin
                    out_valid_d   = 1'b1;
                    alu_result_d  = alu_r;
                    store_value_d = store_in;
                    dest_d        = dest_in;
                    out_ctl_d     = {mem_w_en_in, mem_r_en_in, wb_en_in};
                    if (s_in)
                        status_d = {alu_r[WIDTH-1], alu_r == '0,
                                    is_arith ? alu_c : status_q[1],
                                    is_arith ? alu_v : status_q[0]};
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= S_IDLE;
            cnt_q         <= '0;
            mcand_q       <= '0;
            mplier_q      <= '0;
            acc_q         <= '0;
            hstore_q      <= '0;
            hdest_q       <= '0;
            hctl_q        <= '0;
            hs_q          <= 1'b0;
            mla_q         <= 1'b0;
            out_valid_q   <= 1'b0;
            alu_result_q  <= '0;
            store_value_q <= '0;
            dest_q        <= '0;
            out_ctl_q     <= '0;
            status_q      <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            mcand_q       <= mcand_d;
            mplier_q      <= mplier_d;
            acc_q         <= acc_d;
            hstore_q      <= hstore_d;
            hdest_q       <= hdest_d;
            hctl_q        <= hctl_d;
            hs_q          <= hs_d;
            mla_q         <= mla_d;
            out_valid_q   <= out_valid_d;
            alu_result_q  <= alu_result_d;
            store_value_q <= store_value_d;
            dest_q        <= dest_d;
            out_ctl_q     <= out_ctl_d;
            status_q      <= status_d;
        end
    end

    assign status_bits = status_q;
    assign out_valid   = out_valid_q;
    assign alu_result  = alu_result_q;
    assign store_value = store_value_q;
    assign dest_out    = dest_q;
    assign mem_w_en    = out_ctl_q[2];
    assign mem_r_en    = out_ctl_q[1];
    assign wb_en       = out_ctl_q[0];
endmodule

// File: tb/tb_exe_stage_mc.sv
// tb/tb_exe_stage_mc.sv - directed and randomized bench for exe_stage_mc
module tb_exe_stage_mc;
    localparam int W   = 32;
    localparam int CYC = 8;

    localparam logic [3:0] MOV = 4'b0001, MVN = 4'b1001, ADD = 4'b0010, ADC = 4'b0011,
                           SUB = 4'b0100, SBC = 4'b0101, AND = 4'b0110, ORR = 4'b0111,
                           EOR = 4'b1000, MUL = 4'b1010, MLA = 4'b1011;

    logic         clk = 1'b0, rst = 1'b0;
    logic         in_valid = 0, s_in = 0, carry_in = 0, freeze = 0, flush = 0;
    logic         mem_w_en_in = 0, mem_r_en_in = 0, wb_en_in = 0;
    logic [3:0]   exe_cmd = 0, dest_in = 0;
    logic [W-1:0] rn_value = 0, val2 = 0, store_in = 0;
    logic         in_ready, out_valid, mem_w_en, mem_r_en, wb_en, busy;
    logic [3:0]   status_bits, dest_out;
    logic [W-1:0] alu_result, store_value;

    always #5 clk = ~clk;

    exe_stage_mc #(.WIDTH(W), .MUL_BITS(4)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .exe_cmd(exe_cmd), .s_in(s_in), .carry_in(carry_in),
        .mem_w_en_in(mem_w_en_in), .mem_r_en_in(mem_r_en_in), .wb_en_in(wb_en_in),
        .dest_in(dest_in), .rn_value(rn_value), .val2(val2), .store_in(store_in),
        .freeze(freeze), .flush(flush), .status_bits(status_bits),
        .out_valid(out_valid), .alu_result(alu_result), .store_value(store_value),
        .dest_out(dest_out), .mem_w_en(mem_w_en), .mem_r_en(mem_r_en), .wb_en(wb_en),
        .busy(busy)
    );

    int n_vec = 0, n_err = 0;

    // Transaction-level reference: a pending product with an edge countdown.
    bit           m_busy, m_valid, m_ps;
    int           m_left;
    logic [W-1:0] m_pres, m_pstore, m_res, m_store;
    logic [3:0]   m_pdest, m_dest, m_status;
    logic [2:0]   m_pctl, m_ctl;

    logic [3:0] cmds [11] = '{MOV, MVN, ADD, ADC, SUB, SBC, AND, ORR, EOR, MUL, MLA};
    logic [W-1:0] corner [4] = '{32'h0, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF};

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic m_reset();
        m_busy = 0; m_valid = 0; m_ps = 0; m_left = 0;
        m_pres = 0; m_pstore = 0; m_res = 0; m_store = 0;
        m_pdest = 0; m_dest = 0; m_status = 0; m_pctl = 0; m_ctl = 0;
    endtask

    function automatic void ref_alu(input logic [3:0] cmd, input logic [W-1:0] a, b,
                                    input logic cin, input logic [3:0] st_old,
                                    output logic [W-1:0] r, output logic [3:0] f);
        longint sa, sb, ua, ub, sr, bw;
        logic c, v;
        sa = longint'($signed(a)); sb = longint'($signed(b));
        ua = longint'(a);          ub = longint'(b);
        bw = cin ? 0 : 1;
        c = st_old[1]; v = st_old[0]; sr = 0;
        case (cmd)
            ADD: begin sr = sa + sb;       c = (ua + ub) >= 64'h1_0000_0000; end
            ADC: begin sr = sa + sb + (1 - bw); c = (ua + ub + (1 - bw)) >= 64'h1_0000_0000; end
            SUB: begin sr = sa - sb;       c = ua >= ub; end
            SBC: begin sr = sa - sb - bw;  c = ua >= ub + bw; end
            default: ;
        endcase
        case (cmd)
            MOV: r = b;
            MVN: r = ~b;
            AND: r = a & b;
            ORR: r = a | b;
            EOR: r = a ^ b;
            default: begin
                r = sr[W-1:0];
                v = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
            end
        endcase
        f = {r[W-1], r == 0, c, v};
    endfunction

    task automatic model_edge();
        logic [W-1:0] r;
        logic [3:0]   f;
        if (flush) begin
            m_valid = 0; m_ctl = 0; m_busy = 0;
        end else if (freeze) begin
        end else if (m_busy) begin
            m_left--;
            m_valid = 0; m_ctl = 0;
            if (m_left == 0) begin
                m_busy = 0; m_valid = 1; m_res = m_pres; m_store = m_pstore;
                m_dest = m_pdest; m_ctl = m_pctl;
                if (m_ps) m_status = {m_pres[W-1], m_pres == 0, m_status[1:0]};
            end
        end else if (in_valid) begin
            if (exe_cmd == MUL || exe_cmd == MLA) begin
                m_busy = 1; m_left = CYC;
                m_pres = W'(64'(rn_value) * 64'(val2) + 64'((exe_cmd == MLA) ? store_in : 0));
                m_pstore = store_in; m_pdest = dest_in; m_ps = s_in;
                m_pctl = {mem_w_en_in, mem_r_en_in, wb_en_in};
                m_valid = 0; m_ctl = 0;
            end else begin
                ref_alu(exe_cmd, rn_value, val2, carry_in, m_status, r, f);
                m_valid = 1; m_res = r; m_store = store_in; m_dest = dest_in;
                m_ctl = {mem_w_en_in, mem_r_en_in, wb_en_in};
                if (s_in) m_status = f;
            end
        end else begin
            m_valid = 0; m_ctl = 0;
        end
    endtask

    // Drive one cycle's inputs, check handshake, step model and clock, check outputs.
    task automatic cycle(input logic v, input logic [3:0] cmd, input logic s, input logic cin,
                         input logic [W-1:0] a, b, st, input logic [3:0] d,
                         input logic [2:0] ctl, input logic frz, input logic fl);
        in_valid = v; exe_cmd = cmd; s_in = s; carry_in = cin; rn_value = a; val2 = b;
        store_in = st; dest_in = d; {mem_w_en_in, mem_r_en_in, wb_en_in} = ctl;
        freeze = frz; flush = fl;
        #1;
        chk("in_ready", in_ready, !m_busy && !freeze);
        chk("busy_pre", busy, m_busy);
        model_edge();
        @(posedge clk); #1;
        chk("out_valid", out_valid, m_valid);
        chk("ctl", {mem_w_en, mem_r_en, wb_en}, m_ctl);
        chk("status", status_bits, m_status);
        if (m_valid) begin
            chk("result", alu_result, m_res);
            chk("store", store_value, m_store);
            chk("dest", dest_out, m_dest);
        end
    endtask

    task automatic idle(input logic frz, input logic fl);
        cycle(0, 4'h0, 0, 0, 0, 0, 0, 0, 3'b000, frz, fl);
    endtask

    initial begin
        m_reset();
        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", out_valid, 0);
        chk("rst_status", status_bits, 4'b0000);
        chk("rst_result", alu_result, 0);
        chk("rst_busy", busy, 0);
        rst = 1'b1;
        #1;
        chk("rst_ready", in_ready, 1);

        // ADD overflow into the sign bit
        cycle(1, ADD, 1, 0, 32'h7FFF_FFFF, 32'h1, 32'hAA, 4'd3, 3'b001, 0, 0);
        chk("add_res", alu_result, 32'h8000_0000);
        chk("add_nzcv", status_bits, 4'b1001);
        // SUB equal operands, then AND keeps C/V
        cycle(1, SUB, 1, 0, 32'd5, 32'd5, 32'h0, 4'd4, 3'b010, 0, 0);
        chk("sub_res", alu_result, 32'h0);
        chk("sub_nzcv", status_bits, 4'b0110);
        cycle(1, AND, 1, 0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 4'd5, 3'b001, 0, 0);
        chk("and_nzcv", status_bits, 4'b1010);

        // MUL 7*6: in_ready low for 8 edges, result on the 8th edge after accept
        cycle(1, MUL, 1, 0, 32'd7, 32'd6, 32'h55, 4'd6, 3'b001, 0, 0);
        chk("mul_ready0", in_ready, 0);
        for (int i = 1; i <= CYC; i++) begin
            idle(0, 0);
            if (i < CYC) begin
                chk("mul_bubble", out_valid, 0);
                chk("mul_ready", in_ready, 0);
            end
        end
        chk("mul_res", alu_result, 32'd42);
        chk("mul_valid", out_valid, 1);
        chk("mul_ready1", in_ready, 1);
        chk("mul_nzcv", status_bits, 4'b0010);

        // Set C=V=1, then MLA wraps and must preserve them
        cycle(1, ADD, 1, 0, 32'h8000_0000, 32'h8000_0000, 32'h0, 4'd1, 3'b001, 0, 0);
        chk("addcv_nzcv", status_bits, 4'b0111);
        cycle(1, MLA, 1, 0, 32'hFFFF_FFFF, 32'd2, 32'd3, 4'd7, 3'b001, 0, 0);
        repeat (CYC) idle(0, 0);
        chk("mla_res", alu_result, 32'h1);
        chk("mla_nzcv", status_bits, 4'b0011);

        // Freeze for 3 cycles mid-multiply delays completion by exactly 3 edges
        cycle(1, MUL, 1, 0, 32'd3, 32'd5, 32'h0, 4'd8, 3'b001, 0, 0);
        for (int i = 1; i <= CYC + 3; i++) begin
            idle((i >= 4 && i <= 6), 0);
            chk("frz_valid", out_valid, (i == CYC + 3));
        end
        chk("frz_res", alu_result, 32'd15);

        // Flush mid-multiply aborts without status update
        cycle(1, MUL, 1, 0, 32'd0, 32'd9, 32'h0, 4'd9, 3'b001, 0, 0);
        repeat (3) idle(0, 0);
        idle(0, 1);
        chk("fl_valid", out_valid, 0);
        chk("fl_busy", busy, 0);
        chk("fl_status", status_bits, 4'b0011);
        repeat (CYC) idle(0, 0);

        // Flush on the completion edge wins
        cycle(1, MUL, 1, 0, 32'd0, 32'd9, 32'h0, 4'd9, 3'b001, 0, 0);
        repeat (CYC - 1) idle(0, 0);
        idle(0, 1);
        chk("flc_valid", out_valid, 0);
        chk("flc_status", status_bits, 4'b0011);

        // Asynchronous reset between edges mid-multiply
        cycle(1, MUL, 1, 0, 32'd11, 32'd13, 32'h0, 4'd2, 3'b001, 0, 0);
        repeat (2) idle(0, 0);
        #2 rst = 1'b0;
        #1;
        chk("arst_valid", out_valid, 0);
        chk("arst_status", status_bits, 4'b0000);
        chk("arst_busy", busy, 0);
        chk("arst_result", alu_result, 0);
        m_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        cycle(1, ADD, 0, 0, 32'd2, 32'd3, 32'h0, 4'd1, 3'b001, 0, 0);
        chk("arst_add", alu_result, 32'd5);

        // Randomized traffic against the reference model
        for (int n = 0; n < 400; n++) begin
            logic [W-1:0] a, b;
            a = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 3)] : W'($urandom);
            b = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 3)] : W'($urandom);
            cycle($urandom_range(0, 3) != 0, cmds[$urandom_range(0, 10)], 1'($urandom),
                  1'($urandom), a, b, W'($urandom), 4'($urandom), 3'($urandom),
                  $urandom_range(0, 7) == 0, $urandom_range(0, 15) == 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
